comb_mult: RTL and testbench

- Signed WIDTH x WIDTH multiplier: a purely combinational array-multiplier core followed by a single output register and a ready flag.
- Used as a simple arithmetic leaf block.
- The host applies operands, pulses reset, waits for rdy, then reads p.
- Product is full precision (2*WIDTH bits, two's complement).

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_pp_row.sv | 38 +++
 rtl/comb_mult.sv | 76 +++++++
 tb/tb_comb_mult.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and helpers for the signed array multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Full-precision product width for a w x w signed multiply.
  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One carry-save row: Baugh-Wooley partial products for multiplier bit ROW,
// folded into the running sum/carry vectors with a row of full adders.
module mult_pp_row
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned ROW   = 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [2*WIDTH-1:0] sum_in,
  input  logic [2*WIDTH-1:0] carry_in,
  output logic [2*WIDTH-1:0] sum_out,
  output logic [2*WIDTH-1:0] carry_out
);

  localparam int unsigned PW = prod_width(WIDTH);

  logic [PW-1:0] pp;
  logic [PW-1:0] maj;

  // Partial products: a bit is inverted (NAND) when exactly one of its
  // operand bits is a sign bit; the sign x sign corner stays a plain AND.
  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      pp[ROW+j] = (a[j] & b_bit) ^ ((j == WIDTH - 1) != (ROW == WIDTH - 1));
    end
  end

  // Full-adder row: sum stays in place, carries move up one weight.
  always_comb begin
    sum_out   = sum_in ^ carry_in ^ pp;
    maj       = (sum_in & carry_in) | (sum_in & pp) | (carry_in & pp);
    carry_out = maj << 1;
  end

endmodule

// File: rtl/comb_mult.sv
// Signed WIDTH x WIDTH Baugh-Wooley array multiplier with a registered
// full-precision product and a ready flag.
module comb_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p,
  output logic                      rdy
);

  localparam int unsigned   PW   = prod_width(WIDTH);
  localparam logic [PW-1:0] ONE  = 1;
  // Baugh-Wooley correction: +2^WIDTH and +2^(PW-1), modulo 2^PW.
  localparam logic [PW-1:0] CORR = (ONE << WIDTH) | (ONE << (PW - 1));

  logic [PW-1:0] sum_w   [WIDTH];
  logic [PW-1:0] carry_w [WIDTH];
  logic [PW-1:0] prod;
  logic          cy;

  // Row 0 seeds the carry-save pair; the correction constant rides in
  // the carry vector so no extra adder row is needed for it.
  always_comb begin
    sum_w[0] = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      sum_w[0][j] = (a[j] & b[0]) ^ (j == WIDTH - 1);
    end
    carry_w[0] = CORR;
  end

  genvar k;
  generate
    for (k = 1; k < WIDTH; k++) begin : g_row
      mult_pp_row #(
        .WIDTH (WIDTH),
        .ROW   (k)
      ) u_row (
        .a         (a),
        .b_bit     (b[k]),
        .sum_in    (sum_w[k-1]),
        .carry_in  (carry_w[k-1]),
        .sum_out   (sum_w[k]),
        .carry_out (carry_w[k])
      );
    end
  endgenerate

  // Final ripple carry-propagate adder resolving the carry-save pair.
  always_comb begin
    cy   = 1'b0;
    prod = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      prod[i] = sum_w[WIDTH-1][i] ^ carry_w[WIDTH-1][i] ^ cy;
      cy      = (sum_w[WIDTH-1][i] & carry_w[WIDTH-1][i]) |
                (sum_w[WIDTH-1][i] & cy) |
                (carry_w[WIDTH-1][i] & cy);
    end
  end

  // Output register and ready flag; asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p   <= '0;
      rdy <= 1'b0;
    end else begin
      p   <= $signed(prod);
      rdy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_comb_mult.sv
// Scoreboard bench for comb_mult: the stimulus side pushes the expected
// product for every clock edge taken out of reset; the monitor pops one
// entry per falling edge while rdy is high.
module tb_comb_mult;

  localparam int unsigned W = 8;

  logic                    clk;
  logic                    reset;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic signed [2*W-1:0]   p;
  logic                    rdy;

  logic signed [2*W-1:0]   exp_q[$];
  int                      total;
  int                      bad;
  bit                      mon_en;

  comb_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .p     (p),
    .rdy   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: plain integer multiply at wide precision, then wrap to 2W bits.
  function automatic logic signed [2*W-1:0] model(input int x, input int y);
    longint r;
    r = longint'(x) * longint'(y);
    return r[2*W-1:0];
  endfunction

  // Monitor: each falling edge either consumes one expected product
  // (an edge has been taken out of reset) or confirms the cleared state.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        logic signed [2*W-1:0] e;
        e = exp_q.pop_front();
        check("rdy_high", longint'(rdy), 1);
        check("product", longint'(p), longint'(e));
      end else begin
        check("rdy_idle_low", longint'(rdy), 0);
        check("p_idle_zero", longint'(p), 0);
      end
    end
  end

  // One operand pair sampled by the next rising edge.
  task automatic cycle(input int x, input int y);
    @(negedge clk);
    #1;
    a = W'(x);
    b = W'(y);
    @(posedge clk);
    if (reset) exp_q.push_back(model(x, y));
  endtask

  // Asynchronous reset pulse between edges, then release and one edge.
  task automatic reset_pulse(input int x, input int y);
    @(negedge clk);
    #1;
    a = W'(x);
    b = W'(y);
    #1 reset = 1'b0;
    #1;
    check("async_clear_p", longint'(p), 0);
    check("async_clear_rdy", longint'(rdy), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(x, y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x;
    int y;
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    a      = '0;
    b      = '0;
    #1 reset = 1'b0;
    #1;
    check("reset_p", longint'(p), 0);
    check("reset_rdy", longint'(rdy), 0);
    mon_en = 1'b1;

    reset_pulse(10, 2);
    cycle(-10, 2);
    cycle(10, -2);
    cycle(0, 2);
    cycle(10, 0);
    cycle(127, 127);
    cycle(127, -128);
    cycle(-128, -128);
    cycle(-1, -1);
    cycle(-128, 127);
    cycle(20, 20);
    reset_pulse(20, 20);
    cycle(3, 7);
    cycle(5, 7);
    cycle(5, 7);

    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(255, 0)) - 128;
      y = int'($urandom_range(255, 0)) - 128;
      reset_pulse(x, y);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
